// File: rtl/dma_copy_engine_if.sv
// AXI4 single-beat read/write channel bundle between the DMA copy engine and its RAM slave.
// Data path is fixed at 32 bits; ADDR_W sets the byte-address width.
interface dma_copy_engine_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic              awready;
  logic              wvalid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wready;
  logic              bvalid;
  logic              bready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Single-channel word-by-word memory-to-memory DMA master (read one word, write it back out).
// Optional interrupt output (irq_o / irq_clr_i) is built when DMA_IRQ_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// RD_ADDR | AR channel valid, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// WR_REQ  | AW and W valid together, each dropped after its own handshake
// WR_RESP | both AW and W done, waiting for (or consuming held) B response
// DONE    | one-cycle completion pulse
module dma_copy_engine #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TMO_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_words_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  words_done_o,
  dma_copy_engine_if.master m_axi
`ifdef DMA_IRQ_EN
  ,
  output logic              irq_o,
  input  logic              irq_clr_i
`endif
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]   rem_q, rem_d, words_q, words_d;
  logic [31:0]        data_q, data_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d, abort_q, abort_d;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d, b_pend_q, b_pend_d;
  logic               ar_hs, r_hs, aw_hs, w_hs, b_hs, hs_any, busy;

  assign busy = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                (state_q == WR_REQ)  || (state_q == WR_RESP);

  // All bus outputs decode from registered state so an async reset drops them at once.
  assign m_axi.arvalid = (state_q == RD_ADDR);
  assign m_axi.araddr  = src_q;
  assign m_axi.rready  = (state_q == RD_DATA);
  assign m_axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axi.awaddr  = dst_q;
  assign m_axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axi.wdata   = data_q;
  assign m_axi.wstrb   = m_axi.wvalid ? 4'hF : 4'h0;
  assign m_axi.bready  = (state_q == WR_REQ) || (state_q == WR_RESP);

  assign ar_hs = m_axi.arvalid && m_axi.arready;
  assign r_hs  = m_axi.rvalid  && m_axi.rready;
  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid  && m_axi.wready;
  assign b_hs  = m_axi.bvalid  && m_axi.bready;

  assign busy_o       = busy;
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;
  assign words_done_o = words_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    words_d   = words_q;
    data_d    = data_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    b_pend_d  = b_pend_q;
    abort_d   = abort_q || (busy && abort_i);
    tmo_d     = tmo_q;
    hs_any    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          rem_d   = len_words_i;
          err_d   = 1'b0;
          words_d = '0;
          abort_d = 1'b0;
          if (len_words_i == '0) begin
            state_d = DONE;
          end else if ((src_addr_i[1:0] | dst_addr_i[1:0]) != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        hs_any = ar_hs;
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        hs_any = r_hs;
        if (r_hs) begin
          data_d  = m_axi.rdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        hs_any = aw_hs || w_hs || b_hs;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (b_hs)  b_pend_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        hs_any = b_hs || b_pend_q;
        if (b_hs || b_pend_q) begin
          words_d   = words_q + LEN_W'(1);
          src_d     = src_q + ADDR_W'(4);
          dst_d     = dst_q + ADDR_W'(4);
          rem_d     = rem_q - LEN_W'(1);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          b_pend_d  = 1'b0;
          state_d   = ((rem_q == LEN_W'(1)) || abort_d) ? DONE : RD_ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Watchdog: down-counter reloaded on any handshake or state change, expiry aborts the job.
    if (busy && !hs_any && (tmo_q == '0)) begin
      err_d     = 1'b1;
      state_d   = DONE;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      b_pend_d  = 1'b0;
    end else if (hs_any || (state_d != state_q)) begin
      tmo_d = TMO_LOAD;
    end else if (busy) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      words_q   <= words_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      b_pend_q  <= b_pend_d;
    end
  end

`ifdef DMA_IRQ_EN
  logic irq_q;

  // Set has priority over a simultaneous clear so a completion is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                irq_q <= 1'b0;
    else if (state_q == DONE)  irq_q <= 1'b1;
    else if (irq_clr_i)        irq_q <= 1'b0;
  end

  assign irq_o = irq_q;
`endif

endmodule
